// File: rtl/matrix_decompiler.sv
// matrix_decompiler: reassembles a serial dibit stream into row-major matrix elements with row/col tags.
// Define MATRIX_DECOMPILER_CHECKSUM_EN to receive and check a per-frame XOR trailer after the data.
module matrix_decompiler #(
   parameter int MAX_ELEMENT_SIZE = 8,
   parameter int MAX_SIZE_A       = 32,
   parameter int MAX_SIZE_B       = 32
) (
   input  logic                          inter_refclk,
   input  logic                          rst,
   input  logic                          frame_start,
   input  logic                          valid_dibit_in,
   input  logic [1:0]                    dibit_in,
   input  logic                          ready_in,
   output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
   output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
   output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
   output logic                          valid_data_out,
   output logic                          matrix_done,
   output logic                          overflow_err,
   output logic                          checksum_err
);
   localparam int ES  = MAX_ELEMENT_SIZE;
   localparam int RW  = $clog2(MAX_SIZE_A);
   localparam int CW  = $clog2(MAX_SIZE_B);
   localparam int DPE = ES / 2;
   localparam int DW  = (DPE > 1) ? $clog2(DPE) : 1;

   localparam logic [RW-1:0] ROW_LAST = RW'(MAX_SIZE_A - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [CW-1:0] COL_LAST = CW'(MAX_SIZE_B - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [DW-1:0] DIB_LAST = DW'(DPE - 1);
   localparam logic [DW-1:0] DIB_ONE  = DW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
   localparam logic [1:0] ST_CSUM       = 2'd3;
   localparam logic [1:0] ST_AFTER_DATA = ST_CSUM;
`else
   localparam logic [1:0] ST_AFTER_DATA = ST_DONE;
`endif

   function automatic logic [ES-1:0] shift_dibit(input logic [ES-1:0] word, input logic [1:0] dibit);
      return ES'({word, dibit});
   endfunction

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] dib_q, dib_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [ES-1:0] word_q, word_d;
   logic          out_valid_q, out_valid_d;
   logic [ES-1:0] out_elem_q, out_elem_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          active_s;
   logic          cplt_s;
   logic          pop_s;
   logic [RW-1:0] cplt_row_s;
   logic [CW-1:0] cplt_col_s;
   logic [ES-1:0] shifted_s;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
   logic [ES-1:0] acc_q, acc_d;
   logic          csum_err_q, csum_err_d;
   logic          csum_bad_s;
`endif

   // Next-state: frame sequencing, dibit packing, index advance and the one-deep output slot.
   always_comb begin
      state_d     = state_q;
      dib_d       = dib_q;
      row_d       = row_q;
      col_d       = col_q;
      word_d      = word_q;
      out_valid_d = out_valid_q;
      out_elem_d  = out_elem_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      ovf_d       = ovf_q;
      active_s    = 1'b0;
      cplt_s      = 1'b0;
      cplt_row_s  = row_q;
      cplt_col_s  = col_q;
      shifted_s   = shift_dibit(word_q, dibit_in);
      pop_s       = out_valid_q & ready_in;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
      acc_d       = acc_q;
      csum_bad_s  = 1'b0;
      csum_err_d  = csum_err_q;
`endif

      // frame_start in any state restarts the frame; its own dibit becomes dibit 0 of element 0
      if (frame_start) begin
         state_d  = ST_DATA;
         dib_d    = {DW{1'b0}};
         row_d    = {RW{1'b0}};
         col_d    = {CW{1'b0}};
         active_s = 1'b1;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
         acc_d    = {ES{1'b0}};
`endif
      end else begin
         case (state_q)
            ST_IDLE: state_d  = ST_IDLE;
            ST_DATA: active_s = 1'b1;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
            ST_CSUM: active_s = 1'b1;
`endif
            ST_DONE: state_d  = ST_IDLE;
            default: state_d  = ST_IDLE;
         endcase
      end

      if (active_s && valid_dibit_in) begin
         word_d = shifted_s;
         if (dib_d != DIB_LAST) begin
            dib_d = dib_d + DIB_ONE;
         end else begin
            dib_d = {DW{1'b0}};
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
            if (state_d == ST_CSUM) begin
               csum_bad_s = (acc_d != shifted_s);
               state_d    = ST_DONE;
            end else begin
               acc_d = acc_d ^ shifted_s;
`endif
               cplt_s     = 1'b1;
               cplt_row_s = row_d;
               cplt_col_s = col_d;
               if (col_d != COL_LAST) begin
                  col_d = col_d + COL_ONE;
               end else begin
                  col_d = {CW{1'b0}};
                  if (row_d != ROW_LAST) begin
                     row_d = row_d + ROW_ONE;
                  end else begin
                     row_d   = {RW{1'b0}};
                     state_d = ST_AFTER_DATA;
                  end
               end
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
            end
`endif
         end
      end else begin
         word_d = word_q;
      end

      // a completed element that finds the slot occupied and not draining is dropped
      if (cplt_s) begin
         if (!out_valid_q || pop_s) begin
            out_valid_d = 1'b1;
            out_elem_d  = shifted_s;
            out_row_d   = cplt_row_s;
            out_col_d   = cplt_col_s;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (pop_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      done_d = (state_d == ST_DONE);
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
      csum_err_d = csum_err_q | csum_bad_s;
`endif
   end

   // State and output registers; rst abandons the frame and any pending element.
   always_ff @(posedge inter_refclk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dib_q       <= {DW{1'b0}};
         row_q       <= {RW{1'b0}};
         col_q       <= {CW{1'b0}};
         word_q      <= {ES{1'b0}};
         out_valid_q <= 1'b0;
         out_elem_q  <= {ES{1'b0}};
         out_row_q   <= {RW{1'b0}};
         out_col_q   <= {CW{1'b0}};
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
         acc_q       <= {ES{1'b0}};
         csum_err_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         dib_q       <= dib_d;
         row_q       <= row_d;
         col_q       <= col_d;
         word_q      <= word_d;
         out_valid_q <= out_valid_d;
         out_elem_q  <= out_elem_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
         acc_q       <= acc_d;
         csum_err_q  <= csum_err_d;
`endif
      end
   end

   assign row_addr       = out_row_q;
   assign col_addr       = out_col_q;
   assign matrix_element = out_elem_q;
   assign valid_data_out = out_valid_q;
   assign matrix_done    = done_q;
   assign overflow_err   = ovf_q;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
   assign checksum_err   = csum_err_q;
`else
   assign checksum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_decompiler.sv
// Self-checking bench for matrix_decompiler with a 2x2 matrix of 8-bit elements.
// Builds with or without MATRIX_DECOMPILER_CHECKSUM_EN.
module tb_matrix_decompiler;
   localparam int ES  = 8;
   localparam int A   = 2;
   localparam int B   = 2;
   localparam int DPE = ES / 2;
   localparam int ND  = A * B * DPE;
`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       valid_dibit_in;
   logic [1:0] dibit_in;
   logic       ready_in;
   logic [0:0] row_addr;
   logic [0:0] col_addr;
   logic [7:0] matrix_element;
   logic       valid_data_out;
   logic       matrix_done;
   logic       overflow_err;
   logic       checksum_err;

   int n_cmp    = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit cmp_en   = 1'b0;

   matrix_decompiler #(
      .MAX_ELEMENT_SIZE(ES),
      .MAX_SIZE_A(A),
      .MAX_SIZE_B(B)
   ) dut (
      .inter_refclk(clk),
      .rst(rst),
      .frame_start(frame_start),
      .valid_dibit_in(valid_dibit_in),
      .dibit_in(dibit_in),
      .ready_in(ready_in),
      .row_addr(row_addr),
      .col_addr(col_addr),
      .matrix_element(matrix_element),
      .valid_data_out(valid_data_out),
      .matrix_done(matrix_done),
      .overflow_err(overflow_err),
      .checksum_err(checksum_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a dibit position within the frame plus a one-deep output slot.
   logic       m_valid, m_done, m_ovf, m_cerr, m_in_frame;
   logic [7:0] m_elem, m_word, m_xacc;
   int         m_row, m_col, m_pos;

   always @(posedge clk) begin : ref_model
      bit         pop, got, fend, cbad, inf;
      int         pos, idx;
      logic [7:0] w, x;
      if (rst) begin
         m_valid <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_cerr <= 1'b0;
         m_elem <= 8'h00; m_row <= 0; m_col <= 0;
         m_in_frame <= 1'b0; m_pos <= 0; m_word <= 8'h00; m_xacc <= 8'h00;
      end else begin
         pop = m_valid && ready_in;
         got = 1'b0; fend = 1'b0; cbad = 1'b0; idx = 0;
         pos = m_pos; inf = m_in_frame; w = m_word; x = m_xacc;
         if (frame_start) begin
            inf = 1'b1; pos = 0; x = 8'h00;
         end
         if (inf && valid_dibit_in) begin
            w   = 8'({w, dibit_in});
            pos = pos + 1;
            if (pos <= ND && (pos % DPE) == 0) begin
               got = 1'b1;
               idx = pos / DPE - 1;
               x   = x ^ w;
            end
            if (pos == ND + (CSUM ? DPE : 0)) begin
               fend = 1'b1;
               inf  = 1'b0;
               cbad = CSUM && (w != x);
            end
         end
         if (got) begin
            if (!m_valid || pop) begin
               m_valid <= 1'b1; m_elem <= w; m_row <= idx / B; m_col <= idx % B;
            end else begin
               m_ovf <= 1'b1;
            end
         end else if (pop) begin
            m_valid <= 1'b0;
         end
         m_done <= fend;
         if (cbad) m_cerr <= 1'b1;
         m_pos <= pos; m_in_frame <= inf; m_word <= w; m_xacc <= x;
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("valid", 32'(valid_data_out), 32'(m_valid));
         chk("done", 32'(matrix_done), 32'(m_done));
         chk("overflow", 32'(overflow_err), 32'(m_ovf));
         chk("csum_err", 32'(checksum_err), 32'(m_cerr));
         if (m_valid) begin
            chk("element", 32'(matrix_element), 32'(m_elem));
            chk("row", 32'(row_addr), 32'(m_row));
            chk("col", 32'(col_addr), 32'(m_col));
         end
      end
   end

   always @(negedge clk) begin
      if (matrix_done) done_cnt <= done_cnt + 1;
   end

   task automatic step(input logic fs, input logic v, input logic [1:0] d);
      frame_start    = fs;
      valid_dibit_in = v;
      dibit_in       = d;
      @(negedge clk);
   endtask

   task automatic send_elem(input logic [7:0] e, input logic fs);
      for (int i = 0; i < DPE; i++) begin
         step(fs && (i == 0), 1'b1, e[ES-1-2*i -: 2]);
      end
   endtask

   task automatic send_trailer(input logic [7:0] x);
      if (CSUM) send_elem(x, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step(1'b0, 1'b0, 2'd0);
      rst = 1'b0;
   endtask

   int base;

   initial begin
      rst = 1'b1; frame_start = 1'b0; valid_dibit_in = 1'b0; dibit_in = 2'd0; ready_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_valid", 32'(valid_data_out), 32'd0);
      chk("reset_element", 32'(matrix_element), 32'd0);
      chk("reset_rowcol", 32'({row_addr, col_addr}), 32'd0);
      chk("reset_flags", 32'({matrix_done, overflow_err, checksum_err}), 32'd0);
      rst = 1'b0;
      idle(2);

      // minimal frame, dibits 3,0,1,2 -> 0xC6 at (0,0)
      base = done_cnt;
      send_elem(8'hC6, 1'b1);
      chk("t1_elem0", 32'(matrix_element), 32'h0000_00C6);
      chk("t1_model_elem0", 32'(m_elem), 32'h0000_00C6);
      chk("t1_valid0", 32'(valid_data_out), 32'd1);
      chk("t1_rowcol0", 32'({row_addr, col_addr}), 32'd0);
      idle(1);
      send_elem(8'h5A, 1'b0);
      send_elem(8'h3F, 1'b0);
      send_elem(8'h81, 1'b0);
      send_trailer(8'hC6 ^ 8'h5A ^ 8'h3F ^ 8'h81);
      chk("t1_done_now", 32'(matrix_done), 32'd1);
      idle(3);
      chk("t1_done_count", 32'(done_cnt - base), 32'd1);

      // backpressure: element 1 dropped, element 2 at (1,0)
      pulse_rst();
      ready_in = 1'b0;
      send_elem(8'h11, 1'b1);
      send_elem(8'h22, 1'b0);
      chk("t2_overflow", 32'(overflow_err), 32'd1);
      chk("t2_held_elem", 32'(matrix_element), 32'h0000_0011);
      chk("t2_held_rowcol", 32'({row_addr, col_addr}), 32'd0);
      ready_in = 1'b1;
      idle(1);
      chk("t2_drained", 32'(valid_data_out), 32'd0);
      send_elem(8'h33, 1'b0);
      chk("t2_elem2", 32'(matrix_element), 32'h0000_0033);
      chk("t2_row2", 32'(row_addr), 32'd1);
      chk("t2_col2", 32'(col_addr), 32'd0);
      send_elem(8'h44, 1'b0);
      send_trailer(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
      idle(2);

      // handshake in the same cycle as the next element completes
      pulse_rst();
      ready_in = 1'b0;
      send_elem(8'hA5, 1'b1);
      step(1'b0, 1'b1, 2'd0);
      step(1'b0, 1'b1, 2'd3);
      step(1'b0, 1'b1, 2'd3);
      ready_in = 1'b1;
      step(1'b0, 1'b1, 2'd0);
      chk("t3_valid_kept", 32'(valid_data_out), 32'd1);
      chk("t3_elem1", 32'(matrix_element), 32'h0000_003C);
      chk("t3_col1", 32'(col_addr), 32'd1);
      chk("t3_no_overflow", 32'(overflow_err), 32'd0);
      send_elem(8'h96, 1'b0);
      send_elem(8'h69, 1'b0);
      send_trailer(8'hA5 ^ 8'h3C ^ 8'h96 ^ 8'h69);
      idle(2);

      // frame_start after 6 dibits, then frame_start in the DONE cycle
      pulse_rst();
      send_elem(8'hE4, 1'b1);
      step(1'b0, 1'b1, 2'd2);
      step(1'b0, 1'b1, 2'd1);
      send_elem(8'h7B, 1'b1);
      chk("t4_restart_elem", 32'(matrix_element), 32'h0000_007B);
      chk("t4_restart_rowcol", 32'({row_addr, col_addr}), 32'd0);
      send_elem(8'h12, 1'b0);
      send_elem(8'h34, 1'b0);
      send_elem(8'h56, 1'b0);
      send_trailer(8'h7B ^ 8'h12 ^ 8'h34 ^ 8'h56);
      send_elem(8'hF0, 1'b1);
      chk("t4_done_restart_elem", 32'(matrix_element), 32'h0000_00F0);
      idle(2);

      // rst while an element is pending
      pulse_rst();
      ready_in = 1'b0;
      send_elem(8'hAB, 1'b1);
      chk("t5_pending", 32'(valid_data_out), 32'd1);
      base = done_cnt;
      pulse_rst();
      chk("t5_rst_outputs", 32'({valid_data_out, matrix_done, overflow_err, checksum_err}), 32'd0);
      chk("t5_rst_element", 32'(matrix_element), 32'd0);
      chk("t5_rst_rowcol", 32'({row_addr, col_addr}), 32'd0);
      for (int i = 0; i < ND; i++) step(1'b0, 1'b1, 2'd3);
      idle(2);
      chk("t5_idle_ignored", 32'(valid_data_out), 32'd0);
      chk("t5_no_done", 32'(done_cnt - base), 32'd0);
      ready_in = 1'b1;

`ifdef MATRIX_DECOMPILER_CHECKSUM_EN
      // trailer check: good then bad
      pulse_rst();
      send_elem(8'h01, 1'b1);
      send_elem(8'h02, 1'b0);
      send_elem(8'h04, 1'b0);
      send_elem(8'h08, 1'b0);
      send_elem(8'h0F, 1'b0);
      chk("t6_good_done", 32'(matrix_done), 32'd1);
      chk("t6_good_csum", 32'(checksum_err), 32'd0);
      idle(1);
      send_elem(8'h01, 1'b1);
      send_elem(8'h02, 1'b0);
      send_elem(8'h04, 1'b0);
      send_elem(8'h08, 1'b0);
      send_elem(8'h0E, 1'b0);
      chk("t6_bad_done", 32'(matrix_done), 32'd1);
      chk("t6_bad_csum", 32'(checksum_err), 32'd1);
      idle(2);
      chk("t6_sticky", 32'(checksum_err), 32'd1);
`endif

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_decompiler.md
MATRIX_DECOMPILER -- requirements
Module: matrix_decompiler

Interface
REQ-001 SHALL have parameter MAX_ELEMENT_SIZE, default 8, meaning element width in bits; must be even.
REQ-002 SHALL have parameter MAX_SIZE_A, default 32, meaning matrix rows.
REQ-003 SHALL have parameter MAX_SIZE_B, default 32, meaning matrix columns.
REQ-004 SHALL have port inter_refclk, input, 1 bit: the sole clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port frame_start, input, 1 bit: pulse marking the first dibit of a matrix frame.
REQ-007 SHALL have port valid_dibit_in, input, 1 bit: dibit_in is valid this cycle. There is no input backpressure.
REQ-008 SHALL have port dibit_in, input, 2 bits: serial payload.
REQ-009 SHALL have port ready_in, input, 1 bit: downstream accepts the current element.
REQ-010 SHALL have port row_addr, output, $clog2(MAX_SIZE_A) bits: row of the presented element.
REQ-011 SHALL have port col_addr, output, $clog2(MAX_SIZE_B) bits: column of the presented element.
REQ-012 SHALL have port matrix_element, output, MAX_ELEMENT_SIZE bits: reassembled element.
REQ-013 SHALL have port valid_data_out, output, 1 bit: element and addresses are valid.
REQ-014 SHALL have port matrix_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 SHALL have port overflow_err, output, 1 bit: sticky error flag for a dropped element.
REQ-016 SHALL have port checksum_err, output, 1 bit: sticky error flag for a frame checksum mismatch.

Function
REQ-017 SHALL implement states IDLE, DATA, CSUM and DONE.
- IDLE -> DATA on frame_start.
- DATA -> CSUM, or DATA -> DONE if checksum is disabled, after dibit number MAX_SIZE_A*MAX_SIZE_B*MAX_ELEMENT_SIZE/2.
- CSUM -> DONE after MAX_ELEMENT_SIZE/2 dibits.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL count only dibits where valid_dibit_in=1; dibits received in IDLE without frame_start SHALL be ignored.
REQ-019 SHALL treat a dibit coinciding with frame_start as dibit 0 of element 0.
REQ-020 SHALL pack MAX_ELEMENT_SIZE/2 dibits per element, MSB first: the first dibit goes to bits [MAX_ELEMENT_SIZE-1 -: 2].
REQ-021 SHALL number elements linearly, idx = 0..MAX_SIZE_A*MAX_SIZE_B-1, row-major, with row_addr = idx / MAX_SIZE_B and col_addr = idx % MAX_SIZE_B.
REQ-022 SHALL assert valid_data_out, with element and addresses registered, in the cycle after the element's last dibit.
REQ-023 SHALL hold valid_data_out, matrix_element, row_addr and col_addr stable until a cycle where valid_data_out=1 and ready_in=1; valid_data_out SHALL fall the next cycle unless a new element loads.
REQ-024 SHALL handle an element completing in the same cycle as the pending element's handshake as follows: the new element loads and valid_data_out stays 1.
REQ-025 SHALL handle an element completing while a pending element is not accepted as follows: the new element is dropped, the index still advances, and overflow_err is set.
REQ-026 SHALL pulse matrix_done for exactly one cycle while in DONE; the final pending element MAY still await ready_in.
REQ-027 SHALL handle frame_start in DATA or CSUM as follows: discard the partial element, reset the index and dibit counter to 0, remain in or return to DATA, and leave any pending output untouched.
REQ-028 SHALL handle frame_start in DONE as follows: enter DATA, and still pulse matrix_done.

Reset
REQ-029 SHALL, on rst, go to IDLE and zero the index and dibit counters and the XOR accumulator.
REQ-030 SHALL, on rst, drive valid_data_out=0, matrix_done=0, overflow_err=0, checksum_err=0, matrix_element=0, row_addr=0, col_addr=0.
REQ-031 SHALL apply rst mid-frame by abandoning the frame immediately, including any pending element; no matrix_done is issued.
REQ-032 SHALL give rst priority over every other input.

Configuration
REQ-033 SHALL, with macro MATRIX_DECOMPILER_CHECKSUM_EN defined, enter CSUM after the data dibits and receive a MAX_ELEMENT_SIZE-bit trailer, MSB first; the trailer is the expected XOR of all elements in the frame.
REQ-034 SHALL, with the macro defined, set checksum_err in the DONE cycle on mismatch.
REQ-035 SHALL, without the macro, go DATA -> DONE directly, omit the CSUM state and accumulator, and tie checksum_err to 0.

Verification
REQ-036 SHALL cover a minimal frame with parameters A=2, B=2, ready_in=1 and dibits 3,0,1,2 for the first element -> element 0xC6 at row=0, col=0 one cycle after its 4th dibit; matrix_done pulses once after element 3.
REQ-037 SHALL cover backpressure with ready_in=0 held across a 4-dibit element time -> element 0 is held stable; element 1 is dropped, overflow_err=1, and element 2 reports row=1, col=0.
REQ-038 SHALL cover a handshake in the same cycle as element completion -> valid_data_out stays 1 and the new element appears with no gap.
REQ-039 SHALL cover frame_start reasserted after 6 dibits -> no element from the partial data; the next element reports row=0, col=0.
REQ-040 SHALL cover rst asserted while an element is pending -> next-cycle outputs are all 0, the state is IDLE, and no matrix_done is issued.
REQ-041 SHALL, with MATRIX_DECOMPILER_CHECKSUM_EN defined, cover elements 0x01, 0x02, 0x04, 0x08 with trailer 0x0F -> checksum_err=0; with trailer 0x0E -> checksum_err=1 in the DONE cycle.
